// File: rtl/sfm_pkg.sv
// Shared types and helpers for the SoftEx wide-port to TCDM lane splitter.
package sfm_pkg;

  localparam int unsigned SFM_LANE_W = 32;

  typedef struct packed {
    logic [SFM_LANE_W-1:0] data;
    logic                  opc;
  } sfm_lane_resp_t;

  // Pointer width that stays legal for a single-entry FIFO.
  function automatic int unsigned sfm_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sfm_tcdm_splitter_if.sv
// Wide HCI-style port plus the MP-lane TCDM side, as seen by the splitter.
interface sfm_tcdm_splitter_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned MP = DW / 32
);
  localparam int unsigned LW = sfm_pkg::SFM_LANE_W;

  logic             req_i;
  logic             gnt_o;
  logic [31:0]      add_i;
  logic             wen_i;
  logic [DW/8-1:0]  be_i;
  logic [DW-1:0]    data_i;
  logic [DW-1:0]    r_data_o;
  logic             r_valid_o;
  logic             r_opc_o;

  logic [MP-1:0]    tcdm_req_o;
  logic [MP-1:0]    tcdm_gnt_i;
  logic [MP*LW-1:0] tcdm_add_o;
  logic [MP-1:0]    tcdm_wen_o;
  logic [MP*4-1:0]  tcdm_be_o;
  logic [MP*LW-1:0] tcdm_data_o;
  logic [MP*LW-1:0] tcdm_r_data_i;
  logic [MP-1:0]    tcdm_r_valid_i;
  logic [MP-1:0]    tcdm_r_opc_i;

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i,
    input  tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, tcdm_r_opc_i,
    output gnt_o, r_data_o, r_valid_o, r_opc_o,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
  );

  modport master (
    output req_i, add_i, wen_i, be_i, data_i,
    output tcdm_gnt_i, tcdm_r_data_i, tcdm_r_valid_i, tcdm_r_opc_i,
    input  gnt_o, r_data_o, r_valid_o, r_opc_o,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o
  );

endinterface

// File: rtl/sfm_splitter_lane_fifo.sv
// Per-lane response FIFO; optionally first-word fall-through so a push can pop the same cycle.
module sfm_splitter_lane_fifo
  import sfm_pkg::*;
#(
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  sfm_lane_resp_t wdata,
  input  logic           pop,
  output sfm_lane_resp_t rdata,
  output logic           valid
);

  localparam int unsigned PtrW = sfm_ptr_w(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  sfm_lane_resp_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            empty, full, bypass, do_write, do_read;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CntW'(Depth));
  assign bypass = FallThrough && empty && push;
  assign valid  = !empty || bypass;
  assign rdata  = bypass ? wdata : mem_q[rd_ptr_q];

  // A bypassed word that is popped straight away never touches storage.
  assign do_write = push && !(bypass && pop);
  assign do_read  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_write) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_read)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_write && !do_read)      cnt_d = cnt_q + 1'b1;
    else if (!do_write && do_read) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= wdata;
  end

  // The credit limit in the splitter keeps every lane within Depth entries.
  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/sfm_tcdm_splitter.sv
// Splits one wide memory port into MP independent 32-bit TCDM lanes with grant tracking and
// response realignment. Define SFM_SPLITTER_FALLTHROUGH_EN for fall-through lane FIFOs.
module sfm_tcdm_splitter
  import sfm_pkg::*;
#(
  parameter int unsigned DW         = 256,
  parameter int unsigned MP         = DW / 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  sfm_tcdm_splitter_if.slave bus
);

`ifdef SFM_SPLITTER_FALLTHROUGH_EN
  localparam bit FallThrough = 1'b1;
`else
  localparam bit FallThrough = 1'b0;
`endif
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [MP-1:0]   granted_q, granted_d;
  logic [MP-1:0]   lane_req, lane_gnt, lane_valid, lane_opc;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic            credit_ok, wide_gnt, wide_pop;
  logic [DW-1:0]   r_data;
  sfm_lane_resp_t  lane_head [MP];

  // A partially granted transaction must always be allowed to finish.
  assign credit_ok = (outstanding_q < CntW'(FIFO_DEPTH)) || (granted_q != '0) ||
                     (FallThrough && wide_pop);

  assign lane_req = {MP{bus.req_i & credit_ok}} & ~granted_q;
  assign lane_gnt = bus.tcdm_gnt_i & lane_req;
  assign wide_gnt = bus.req_i & (&(granted_q | lane_gnt));
  assign wide_pop = &lane_valid;

  assign bus.tcdm_req_o  = lane_req;
  assign bus.gnt_o       = wide_gnt;
  assign bus.tcdm_wen_o  = {MP{bus.wen_i}};
  assign bus.tcdm_be_o   = bus.be_i;
  assign bus.tcdm_data_o = bus.data_i;
  assign bus.r_valid_o   = wide_pop;
  assign bus.r_data_o    = r_data;
  assign bus.r_opc_o     = wide_pop & (|lane_opc);

  always_comb begin
    granted_d     = granted_q | lane_gnt;
    outstanding_d = outstanding_q;
    if (wide_gnt) granted_d = '0;
    if (wide_gnt && !wide_pop)      outstanding_d = outstanding_q + 1'b1;
    else if (!wide_gnt && wide_pop) outstanding_d = outstanding_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      granted_q     <= '0;
      outstanding_q <= '0;
    end else begin
      granted_q     <= granted_d;
      outstanding_q <= outstanding_d;
    end
  end

  for (genvar ii = 0; ii < MP; ii++) begin : g_lane
    sfm_lane_resp_t push_resp;

    assign push_resp.data = bus.tcdm_r_data_i[ii*SFM_LANE_W +: SFM_LANE_W];
    assign push_resp.opc  = bus.tcdm_r_opc_i[ii];
    assign bus.tcdm_add_o[ii*SFM_LANE_W +: SFM_LANE_W] = bus.add_i + 32'(4 * ii);

    sfm_splitter_lane_fifo #(
      .Depth       (FIFO_DEPTH),
      .FallThrough (FallThrough)
    ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (bus.tcdm_r_valid_i[ii]),
      .wdata (push_resp),
      .pop   (wide_pop),
      .rdata (lane_head[ii]),
      .valid (lane_valid[ii])
    );

    // Heads are only meaningful while every lane holds a word.
    assign r_data[ii*SFM_LANE_W +: SFM_LANE_W] = wide_pop ? lane_head[ii].data : '0;
    assign lane_opc[ii] = lane_head[ii].opc;
  end

endmodule

// File: tb/tb_sfm_tcdm_splitter.sv
// Scoreboard bench for sfm_tcdm_splitter with a per-lane TCDM responder model.
module tb_sfm_tcdm_splitter;

  localparam int unsigned DW         = 256;
  localparam int unsigned MP         = DW / 32;
  localparam int unsigned FIFO_DEPTH = 2;
`ifdef SFM_SPLITTER_FALLTHROUGH_EN
  localparam int RespLat = 0;
`else
  localparam int RespLat = 1;
`endif
  localparam int MaxTxn = 64;

  typedef struct {
    int            txn;
    logic [DW-1:0] data;
    logic          opc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [MP-1:0] hold = '0;
  int n_total = 0, n_bad = 0, cyc = 0, txn_cnt = 0, err_txn = -1, last_pop = -100, opc_seen = 0;
  int pend [MP][16];
  int pwr [MP];
  int prd [MP];
  int resp_cnt [MaxTxn];
  int ready_cyc [MaxTxn];
  exp_t exp_q [$];

  sfm_tcdm_splitter_if #(.DW(DW), .MP(MP)) bus ();

  sfm_tcdm_splitter #(
    .DW         (DW),
    .MP         (MP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_data(input int t, input int ii);
    logic [31:0] v;
    v      = 32'(t) << 8;
    v[7:0] = 8'(8'hA0 + ii);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_add(input logic [31:0] base);
    logic [DW-1:0] v;
    for (int ii = 0; ii < int'(MP); ii++) v[ii*32 +: 32] = base + 32'(4 * ii);
    return v;
  endfunction

  // Lane grant tracking, expected-result push and response checking.
  initial begin
    exp_t e;
    int   exp_c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int ii = 0; ii < int'(MP); ii++) begin
          if (bus.tcdm_req_o[ii] && bus.tcdm_gnt_i[ii]) begin
            pend[ii][pwr[ii] % 16] = txn_cnt;
            pwr[ii]++;
          end
        end
        if (bus.gnt_o) begin
          e.txn = txn_cnt;
          for (int ii = 0; ii < int'(MP); ii++) e.data[ii*32 +: 32] = lane_data(txn_cnt, ii);
          e.opc = (txn_cnt == err_txn);
          exp_q.push_back(e);
          txn_cnt++;
        end
        if (bus.r_valid_o) begin
          if (exp_q.size() == 0) begin
            check("rvalid_unexpected", DW'(bus.r_valid_o), DW'(0));
          end else begin
            e = exp_q.pop_front();
            check("r_data", bus.r_data_o, e.data);
            check("r_opc", DW'(bus.r_opc_o), DW'(e.opc));
            check("resp_complete", DW'(resp_cnt[e.txn]), DW'(MP));
            exp_c = ready_cyc[e.txn] + RespLat;
            if (exp_c < last_pop + 1) exp_c = last_pop + 1;
            check("r_latency", DW'(cyc), DW'(exp_c));
            last_pop = cyc;
            if (bus.r_opc_o) opc_seen++;
          end
        end
      end
    end
  end

  // TCDM responder: one in-order response per lane per cycle, one cycle after the grant.
  initial begin
    int t;
    bus.tcdm_r_valid_i = '0;
    bus.tcdm_r_data_i  = '0;
    bus.tcdm_r_opc_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int ii = 0; ii < int'(MP); ii++) begin
        bus.tcdm_r_valid_i[ii] = 1'b0;
        bus.tcdm_r_opc_i[ii]   = 1'b0;
        if (!rst && !hold[ii] && pwr[ii] != prd[ii]) begin
          t = pend[ii][prd[ii] % 16];
          prd[ii]++;
          bus.tcdm_r_valid_i[ii]        = 1'b1;
          bus.tcdm_r_data_i[ii*32 +: 32] = lane_data(t, ii);
          bus.tcdm_r_opc_i[ii]          = (t == err_txn) && (ii == 5);
          resp_cnt[t]++;
          if (resp_cnt[t] == int'(MP)) ready_cyc[t] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [DW/8-1:0] be,
                           input logic [DW-1:0] d);
    bus.req_i  = 1'b1;
    bus.add_i  = a;
    bus.wen_i  = w;
    bus.be_i   = be;
    bus.data_i = d;
  endtask

  task automatic wait_gnt(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int n = 0; n < max_cyc && !seen; n++) begin
      @(negedge clk);
      seen = bus.gnt_o;
      tick();
    end
    check(tag, DW'(seen), DW'(1));
    bus.req_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check(tag, DW'(exp_q.size()), DW'(0));
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wbe;
    for (int i = 0; i < MaxTxn; i++) begin
      resp_cnt[i]  = 0;
      ready_cyc[i] = -1000;
    end
    for (int ii = 0; ii < int'(MP); ii++) begin
      pwr[ii] = 0;
      prd[ii] = 0;
    end
    bus.req_i      = 1'b0;
    bus.add_i      = '0;
    bus.wen_i      = 1'b1;
    bus.be_i       = '0;
    bus.data_i     = '0;
    bus.tcdm_gnt_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", DW'(bus.gnt_o), DW'(0));
    check("rst_rvalid", DW'(bus.r_valid_o), DW'(0));
    check("rst_rdata", bus.r_data_o, DW'(0));
    check("rst_ropc", DW'(bus.r_opc_o), DW'(0));
    check("rst_tcdm_req", DW'(bus.tcdm_req_o), DW'(0));
    tick();
    rst = 1'b0;
    tick();

    // All lanes grant at once, read at 0x1000
    bus.tcdm_gnt_i = '1;
    drive_req(32'h1000, 1'b1, '1, '0);
    @(negedge clk);
    check("t1_gnt", DW'(bus.gnt_o), DW'(1));
    check("t1_tcdm_req", DW'(bus.tcdm_req_o), DW'(8'hFF));
    check("t1_tcdm_add", bus.tcdm_add_o, exp_add(32'h1000));
    check("t1_tcdm_wen", DW'(bus.tcdm_wen_o), DW'(8'hFF));
    tick();
    bus.req_i = 1'b0;
    drain("t1_drain");

    // Write with a byte-enable pattern
    for (int ii = 0; ii < int'(MP); ii++) wdata[ii*32 +: 32] = $urandom();
    wbe = 32'hF0F0_A5C3;
    drive_req(32'h3000, 1'b0, wbe, wdata);
    @(negedge clk);
    check("wr_gnt", DW'(bus.gnt_o), DW'(1));
    check("wr_tcdm_wen", DW'(bus.tcdm_wen_o), DW'(0));
    check("wr_tcdm_be", DW'(bus.tcdm_be_o), DW'(wbe));
    check("wr_tcdm_data", bus.tcdm_data_o, wdata);
    tick();
    bus.req_i = 1'b0;
    drain("wr_drain");

    // Lane 3 granted two cycles late
    bus.tcdm_gnt_i = 8'hF7;
    drive_req(32'h2000, 1'b1, '1, '0);
    @(negedge clk);
    check("t2_req_c0", DW'(bus.tcdm_req_o), DW'(8'hFF));
    check("t2_gnt_c0", DW'(bus.gnt_o), DW'(0));
    tick();
    @(negedge clk);
    check("t2_req_c1", DW'(bus.tcdm_req_o), DW'(8'h08));
    check("t2_gnt_c1", DW'(bus.gnt_o), DW'(0));
    tick();
    bus.tcdm_gnt_i = '1;
    @(negedge clk);
    check("t2_req_c2", DW'(bus.tcdm_req_o), DW'(8'h08));
    check("t2_gnt_c2", DW'(bus.gnt_o), DW'(1));
    tick();
    bus.req_i = 1'b0;
    drain("t2_drain");

    // Credit exhaustion with responses withheld
    hold = '1;
    drive_req(32'h4000, 1'b1, '1, '0);
    @(negedge clk);
    check("t3_gnt0", DW'(bus.gnt_o), DW'(1));
    tick();
    @(negedge clk);
    check("t3_gnt1", DW'(bus.gnt_o), DW'(1));
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t3_no_req", DW'(bus.tcdm_req_o), DW'(0));
      check("t3_no_gnt", DW'(bus.gnt_o), DW'(0));
      if (i == 1) hold = '0;
      else tick();
    end
    wait_gnt("t3_gnt2", 8);
    drain("t3_drain");

    // Lane 0 returns three cycles after the others
    hold = 8'h01;
    drive_req(32'h5000, 1'b1, '1, '0);
    @(negedge clk);
    check("t4_gnt", DW'(bus.gnt_o), DW'(1));
    tick();
    bus.req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_no_early_rvalid", DW'(bus.r_valid_o), DW'(0));
      if (i == 2) hold = '0;
      tick();
    end
    drain("t4_drain");

    // Lane 5 error on one transaction, clean one right behind it
    err_txn = txn_cnt;
    drive_req(32'h6000, 1'b1, '1, '0);
    @(negedge clk);
    check("t5_gnt0", DW'(bus.gnt_o), DW'(1));
    tick();
    @(negedge clk);
    check("t5_gnt1", DW'(bus.gnt_o), DW'(1));
    tick();
    bus.req_i = 1'b0;
    drain("t5_drain");
    check("t5_opc_count", DW'(opc_seen), DW'(1));

    check("final_queue_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
